// File: rtl/z_pkg.sv
// Shared definitions for the Z result sequencer: controller states and default sizing.
package z_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        HOLD,
        DRAIN_LO,
        DRAIN_HI
    } z_state_t;

endpackage

// File: rtl/z_wait_timer.sv
// Wait-cycle counter for multi-cycle ALU ops; expire flags the last permitted WAIT cycle.
module z_wait_timer #(
    parameter int  TIMEOUT = 64,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/z_result_sequencer.sv
// Z result register: atomic LOW/HIGH capture from single-cycle or handshaked multi-cycle ALU
// ops, with a two-beat LOW-then-HIGH drain onto the internal bus.
module z_result_sequencer
    import z_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               z_in,
    input  logic               alu_start,
    input  logic               alu_done,
    input  logic [2*WIDTH-1:0] d,
    input  logic               z_low_out_sel,
    input  logic               z_high_out_sel,
    input  logic               drain,
    output logic [WIDTH-1:0]   bus_out,
    output logic               bus_valid,
    output logic [WIDTH-1:0]   z_low_q,
    output logic [WIDTH-1:0]   z_high_q,
    output logic               full,
    output logic               busy,
    output logic               timeout_err
);

    z_state_t state, state_n;
    logic     capture;
    logic     full_n;
    logic     terr_n;
    logic     load;
    logic     expire;

    // Counter stops at the expiry value; the FSM leaves WAIT on that same cycle.
    z_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .clr    (clr),
        .load   (load),
        .en     ((state == WAIT) && !expire),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            z_low_q     <= '0;
            z_high_q    <= '0;
            full        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            full        <= full_n;
            timeout_err <= terr_n;
            if (capture) begin
                z_low_q  <= d[WIDTH-1:0];
                z_high_q <= d[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_comb begin
        state_n = state;
        capture = 1'b0;
        full_n  = full;
        terr_n  = timeout_err;
        load    = 1'b0;
        case (state)
            IDLE, HOLD: begin
                if (z_in) begin
                    capture = 1'b1;
                    full_n  = 1'b1;
                    state_n = HOLD;
                end else if (alu_start) begin
                    load    = 1'b1;
                    terr_n  = 1'b0;
                    state_n = WAIT;
                end else if (drain && (state == HOLD)) begin
                    state_n = DRAIN_LO;
                end
            end
            WAIT: begin
                if (alu_done) begin
                    capture = 1'b1;
                    full_n  = 1'b1;
                    state_n = HOLD;
                end else if (expire) begin
                    terr_n  = 1'b1;
                    state_n = full ? HOLD : IDLE;
                end
            end
            DRAIN_LO: state_n = DRAIN_HI;
            DRAIN_HI: state_n = HOLD;
            default:  state_n = IDLE;
        endcase
    end

    // Drain beats override the static selects; LOW wins when both selects are high.
    always_comb begin
        bus_out   = '0;
        bus_valid = 1'b0;
        case (state)
            DRAIN_LO: begin
                bus_out   = z_low_q;
                bus_valid = 1'b1;
            end
            DRAIN_HI: begin
                bus_out   = z_high_q;
                bus_valid = 1'b1;
            end
            default: begin
                if (z_low_out_sel) begin
                    bus_out = z_low_q;
                end else if (z_high_out_sel) begin
                    bus_out = z_high_q;
                end
            end
        endcase
    end

    assign busy = (state == WAIT);

endmodule

// File: tb/tb_z_result_sequencer.sv
// Bench for z_result_sequencer: directed scenarios plus randomized traffic against a
// transaction-level model of the result register.
module tb_z_result_sequencer;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 6;

    logic               clk;
    logic               clr;
    logic               z_in;
    logic               alu_start;
    logic               alu_done;
    logic [2*WIDTH-1:0] d;
    logic               z_low_out_sel;
    logic               z_high_out_sel;
    logic               drain;
    logic [WIDTH-1:0]   bus_out;
    logic               bus_valid;
    logic [WIDTH-1:0]   z_low_q;
    logic [WIDTH-1:0]   z_high_q;
    logic               full;
    logic               busy;
    logic               timeout_err;

    int checkCount = 0;
    int passCount  = 0;

    // Model: result halves, valid flag, sticky error, op in flight, beats of drain left.
    logic [WIDTH-1:0] mLow;
    logic [WIDTH-1:0] mHigh;
    bit               mFull;
    bit               mErr;
    bit               mWaiting;
    int               mWaitCycles;
    int               mDrainLeft;

    z_result_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .clr            (clr),
        .z_in           (z_in),
        .alu_start      (alu_start),
        .alu_done       (alu_done),
        .d              (d),
        .z_low_out_sel  (z_low_out_sel),
        .z_high_out_sel (z_high_out_sel),
        .drain          (drain),
        .bus_out        (bus_out),
        .bus_valid      (bus_valid),
        .z_low_q        (z_low_q),
        .z_high_q       (z_high_q),
        .full           (full),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mLow        = '0;
        mHigh       = '0;
        mFull       = 1'b0;
        mErr        = 1'b0;
        mWaiting    = 1'b0;
        mWaitCycles = 0;
        mDrainLeft  = 0;
    endtask

    // One clock edge of the register's contract, from the inputs present at that edge.
    task automatic modelStep();
        if (mDrainLeft > 0) begin
            mDrainLeft--;
        end else if (mWaiting) begin
            if (alu_done) begin
                mLow     = d[WIDTH-1:0];
                mHigh    = d[2*WIDTH-1:WIDTH];
                mFull    = 1'b1;
                mWaiting = 1'b0;
            end else if (mWaitCycles == TIMEOUT - 1) begin
                mErr     = 1'b1;
                mWaiting = 1'b0;
            end else begin
                mWaitCycles++;
            end
        end else if (z_in) begin
            mLow  = d[WIDTH-1:0];
            mHigh = d[2*WIDTH-1:WIDTH];
            mFull = 1'b1;
        end else if (alu_start) begin
            mWaiting    = 1'b1;
            mWaitCycles = 0;
            mErr        = 1'b0;
        end else if (drain && mFull) begin
            mDrainLeft = 2;
        end
    endtask

    function automatic logic [WIDTH-1:0] modelBus();
        if (mDrainLeft == 2) return mLow;
        if (mDrainLeft == 1) return mHigh;
        if (z_low_out_sel)   return mLow;
        if (z_high_out_sel)  return mHigh;
        return '0;
    endfunction

    task automatic compareAll(input string tag);
        checkOutput({tag, ".low"},   64'(z_low_q),     64'(mLow));
        checkOutput({tag, ".high"},  64'(z_high_q),    64'(mHigh));
        checkOutput({tag, ".full"},  64'(full),        64'(mFull));
        checkOutput({tag, ".busy"},  64'(busy),        64'(mWaiting));
        checkOutput({tag, ".terr"},  64'(timeout_err), 64'(mErr));
        checkOutput({tag, ".bus"},   64'(bus_out),     64'(modelBus()));
        checkOutput({tag, ".valid"}, 64'(bus_valid),   64'(mDrainLeft > 0));
    endtask

    task automatic applyStimulus(input string tag, input bit zi, input bit st, input bit dn, input bit dr,
                                 input bit lsel, input bit hsel, input logic [63:0] dd);
        @(negedge clk);
        z_in           = zi;
        alu_start      = st;
        alu_done       = dn;
        drain          = dr;
        z_low_out_sel  = lsel;
        z_high_out_sel = hsel;
        d              = dd;
        @(posedge clk);
        modelStep();
        #1;
        compareAll(tag);
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 0, 0, 0, 0, 0, 0, 64'h0);
    endtask

    // Raise clr between edges and expect the outputs to drop before any clock edge.
    task automatic clrPulse(input string tag);
        @(negedge clk);
        z_in = 0; alu_start = 0; alu_done = 0; drain = 0;
        z_low_out_sel = 0; z_high_out_sel = 0;
        #2 clr = 1'b1;
        #1;
        modelReset();
        compareAll({tag, ".async"});
        @(posedge clk);
        #1;
        compareAll({tag, ".held"});
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1;
        z_in = 0; alu_start = 0; alu_done = 0; drain = 0;
        z_low_out_sel = 0; z_high_out_sel = 0; d = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        compareAll("reset");
        @(negedge clk);
        clr = 1'b0;

        // Single-cycle capture, then a static LOW select.
        applyStimulus("zin", 1, 0, 0, 0, 0, 0, 64'h1111_2222_3333_4444);
        checkOutput("zin.high_const", 64'(z_high_q), 64'h11112222);
        checkOutput("zin.low_const",  64'(z_low_q),  64'h33334444);
        applyStimulus("lsel", 0, 0, 0, 0, 1, 0, 64'h0);
        checkOutput("lsel.bus_const", 64'(bus_out), 64'h33334444);

        // Multi-cycle op completing on the fifth WAIT cycle.
        applyStimulus("mstart", 0, 1, 0, 0, 0, 0, 64'h0);
        for (int i = 0; i < 4; i++) idle("mwait");
        checkOutput("mwait.busy_const", 64'(busy), 64'h1);
        applyStimulus("mdone", 0, 0, 1, 0, 0, 0, 64'hDEAD_BEEF_0000_0007);
        checkOutput("mdone.high_const", 64'(z_high_q), 64'hDEADBEEF);
        checkOutput("mdone.low_const",  64'(z_low_q),  64'h7);
        checkOutput("mdone.busy_const", 64'(busy),     64'h0);

        // Timeout: no done, registers untouched, error sticky until the next start.
        applyStimulus("tstart", 0, 1, 0, 0, 0, 0, 64'h0);
        for (int i = 0; i < TIMEOUT; i++) idle("twait");
        checkOutput("tout.err_const",  64'(timeout_err), 64'h1);
        checkOutput("tout.busy_const", 64'(busy),        64'h0);
        checkOutput("tout.low_const",  64'(z_low_q),     64'h7);
        idle("tout.sticky");
        applyStimulus("trestart", 0, 1, 0, 0, 0, 0, 64'h0);
        checkOutput("trestart.err_const", 64'(timeout_err), 64'h0);
        applyStimulus("trestart.done", 0, 0, 1, 0, 0, 0, 64'h0000_000B_0000_000A);

        // Drain, with z_in attempts during both beats.
        applyStimulus("drain.req", 0, 0, 0, 1, 0, 0, 64'h0);
        checkOutput("drain.lo_const", 64'(bus_out), 64'hA);
        applyStimulus("drain.hi", 1, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("drain.hi_const", 64'(bus_out), 64'hB);
        applyStimulus("drain.end", 1, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("drain.end_valid", 64'(bus_valid), 64'h0);
        checkOutput("drain.end_low",   64'(z_low_q),   64'hA);

        // z_in beats alu_start; both selects pick LOW.
        applyStimulus("prio", 1, 1, 0, 0, 1, 1, 64'h5555_6666_7777_8888);
        checkOutput("prio.busy_const", 64'(busy),    64'h0);
        checkOutput("prio.bus_const",  64'(bus_out), 64'h77778888);

        // Clear mid-WAIT and mid-DRAIN_LO; drain afterwards must be ignored.
        applyStimulus("cw.start", 0, 1, 0, 0, 0, 0, 64'h0);
        idle("cw.wait");
        clrPulse("clr_wait");
        applyStimulus("cd.cap", 1, 0, 0, 0, 0, 0, 64'h0000_0002_0000_0001);
        applyStimulus("cd.drain", 0, 0, 0, 1, 0, 0, 64'h0);
        clrPulse("clr_drain");
        applyStimulus("post_clr.drain", 0, 0, 0, 1, 0, 0, 64'h0);
        checkOutput("post_clr.valid_const", 64'(bus_valid), 64'h0);

        // Randomized traffic with occasional asynchronous clears.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                clrPulse("rnd_clr");
            end else begin
                applyStimulus("rnd",
                              $urandom_range(0, 9) == 0,
                              $urandom_range(0, 9) == 0,
                              $urandom_range(0, 5) == 0,
                              $urandom_range(0, 5) == 0,
                              $urandom_range(0, 1) == 1,
                              $urandom_range(0, 1) == 1,
                              {$urandom(), $urandom()});
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
